seven_segment_scan_controller: RTL and testbench

Time-multiplexed driver for a parametrised bank of common-anode 7-segment hex digits.
- Captures a packed multi-nibble value and decodes each nibble with the team's standard active-low hex segment encoding.
- Scans one digit at a time, with optional leading-zero blanking and per-digit blinking.
- Sits between the CPU's memory-mapped display register and the board's segment/anode pins.
- Updates are frame-synchronous so a digit never shows a partially updated value.

---
 rtl/seven_segment_scan_controller.sv | 165 ++++++++++++++++
 tb/tb_seven_segment_scan_controller.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed common-anode hex display driver: frame-synchronous value updates,
// leading-zero blanking and per-digit blinking.
module seven_segment_scan_controller #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  I_CLK,
  input  logic                  I_NRESET,
  input  logic                  I_ENABLE,
  input  logic                  I_LOAD,
  input  logic [4*DIGITS-1:0]   I_VALUE,
  input  logic [DIGITS-1:0]     I_BLINK_MASK,
  input  logic                  I_BLANK_LEADING,
  output logic [6:0]            O_SEGMENTS,
  output logic [DIGITS-1:0]     O_DIGIT_SEL,
  output logic                  O_FRAME_DONE
);

  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W   = $clog2(SCAN_DIV);
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0]   LAST_CNT   = CNT_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] LAST_BLINK = BLINK_W'(BLINK_FRAMES - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      scanCnt_q, scanCnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [DIGITS-1:0]     shadowMask_q, shadowMask_d;
  logic [4*DIGITS-1:0]   display_q, display_d;
  logic [DIGITS-1:0]     dispMask_q, dispMask_d;
  logic                  pending_q, pending_d;
  logic [BLINK_W-1:0]    blinkCnt_q, blinkCnt_d;
  logic                  blinkPhase_q, blinkPhase_d;
  logic [6:0]            segments_q, segments_d;
  logic [DIGITS-1:0]     digitSel_q, digitSel_d;
  logic                  frameDone_q, frameDone_d;

  logic       scanning;
  logic       slotEnd;
  logic       frameEnd;
  logic       transfer;
  logic [3:0] nibble;
  logic       leadBlank;
  logic       blinkBlank;

  function automatic logic [6:0] hexToSeg(input logic [3:0] hex);
    case (hex)
      4'h0: hexToSeg = 7'b1000000;
      4'h1: hexToSeg = 7'b1111001;
      4'h2: hexToSeg = 7'b0100100;
      4'h3: hexToSeg = 7'b0110000;
      4'h4: hexToSeg = 7'b0011001;
      4'h5: hexToSeg = 7'b0010010;
      4'h6: hexToSeg = 7'b0000010;
      4'h7: hexToSeg = 7'b1111000;
      4'h8: hexToSeg = 7'b0000000;
      4'h9: hexToSeg = 7'b0011000;
      4'hA: hexToSeg = 7'b0001000;
      4'hB: hexToSeg = 7'b0000011;
      4'hC: hexToSeg = 7'b1000110;
      4'hD: hexToSeg = 7'b0100001;
      4'hE: hexToSeg = 7'b0000110;
      default: hexToSeg = 7'b0001110;
    endcase
  endfunction

  assign scanning   = (state_q == SCAN) && I_ENABLE;
  assign slotEnd    = scanning && (scanCnt_q == LAST_CNT);
  assign frameEnd   = slotEnd && (idx_q == LAST_IDX);
  // While dark there is no frame to tear, so a pending value can land at once.
  assign transfer   = pending_q && ((state_q == IDLE) || frameEnd);
  assign nibble     = display_q[4*idx_q +: 4];
  assign leadBlank  = I_BLANK_LEADING && (idx_q != '0) &&
                      ((display_q >> {idx_q, 2'b00}) == '0);
  assign blinkBlank = blinkPhase_q && dispMask_q[idx_q];

  always_comb begin
    state_d      = I_ENABLE ? SCAN : IDLE;
    scanCnt_d    = '0;
    idx_d        = '0;
    shadow_d     = shadow_q;
    shadowMask_d = shadowMask_q;
    display_d    = display_q;
    dispMask_d   = dispMask_q;
    pending_d    = pending_q;
    blinkCnt_d   = blinkCnt_q;
    blinkPhase_d = blinkPhase_q;
    segments_d   = 7'b1111111;
    digitSel_d   = '1;
    frameDone_d  = frameEnd;

    if (scanning) begin
      scanCnt_d  = slotEnd ? '0 : scanCnt_q + 1'b1;
      idx_d      = idx_q;
      if (slotEnd) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      segments_d = (leadBlank || blinkBlank) ? 7'b1111111 : hexToSeg(nibble);
      digitSel_d = ~(DIGITS'(1) << idx_q);
    end

    if (frameEnd) begin
      if (blinkCnt_q == LAST_BLINK) begin
        blinkCnt_d   = '0;
        blinkPhase_d = ~blinkPhase_q;
      end else begin
        blinkCnt_d = blinkCnt_q + 1'b1;
      end
    end

    if (transfer) begin
      display_d  = shadow_q;
      dispMask_d = shadowMask_q;
      pending_d  = 1'b0;
    end

    // A load on the boundary edge wins over the clear, so it shows one frame later.
    if (I_LOAD) begin
      shadow_d     = I_VALUE;
      shadowMask_d = I_BLINK_MASK;
      pending_d    = 1'b1;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (!I_NRESET) begin
      state_q      <= IDLE;
      scanCnt_q    <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      shadowMask_q <= '0;
      display_q    <= '0;
      dispMask_q   <= '0;
      pending_q    <= 1'b0;
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
      segments_q   <= 7'b1111111;
      digitSel_q   <= '1;
      frameDone_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      scanCnt_q    <= scanCnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      shadowMask_q <= shadowMask_d;
      display_q    <= display_d;
      dispMask_q   <= dispMask_d;
      pending_q    <= pending_d;
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
      segments_q   <= segments_d;
      digitSel_q   <= digitSel_d;
      frameDone_q  <= frameDone_d;
    end
  end

  assign O_SEGMENTS   = segments_q;
  assign O_DIGIT_SEL  = digitSel_q;
  assign O_FRAME_DONE = frameDone_q;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Self-checking bench for seven_segment_scan_controller: a frame/tick-count model checked
// every cycle, plus hand-computed literal checkpoints for the directed scenarios.
module tb_seven_segment_scan_controller;

  localparam int DIGITS       = 4;
  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = DIGITS * SCAN_DIV;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic        clk = 1'b0;
  logic        nReset;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  blinkMask;
  logic        blankLeading;
  logic [6:0]  segments;
  logic [3:0]  digitSel;
  logic        frameDone;

  int errors = 0;
  int checks = 0;

  seven_segment_scan_controller #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .I_CLK(clk), .I_NRESET(nReset), .I_ENABLE(enable), .I_LOAD(load),
    .I_VALUE(value), .I_BLINK_MASK(blinkMask), .I_BLANK_LEADING(blankLeading),
    .O_SEGMENTS(segments), .O_DIGIT_SEL(digitSel), .O_FRAME_DONE(frameDone)
  );

  always #5 clk = ~clk;

  // Model: scanning position is a plain tick count since scanning began, blink phase is
  // derived from the number of completed frames since reset.
  bit          modelValid = 0;
  bit          running    = 0;
  int          tick       = 0;
  int          frames     = 0;
  int          curDigit   = 0;
  logic [15:0] mShadow    = '0;
  logic [15:0] mDisp      = '0;
  logic [3:0]  mShMask    = '0;
  logic [3:0]  mDMask     = '0;
  bit          mPending   = 0;
  logic [6:0]  expSeg     = 7'b1111111;
  logic [3:0]  expSel     = 4'b1111;
  logic        expFd      = 1'b0;

  function automatic logic [6:0] modelDigit(input int k);
    bit allZero = 1;
    for (int j = k; j < DIGITS; j++)
      if (mDisp[4*j +: 4] != 4'h0) allZero = 0;
    if (blankLeading && k > 0 && allZero) return 7'b1111111;
    if (((frames / BLINK_FRAMES) % 2) == 1 && mDMask[k]) return 7'b1111111;
    return SEG_TABLE[mDisp[4*k +: 4]];
  endfunction

  always @(posedge clk) begin
    if (!nReset) begin
      modelValid = 1;
      running  = 0;
      tick     = 0;
      frames   = 0;
      mShadow  = '0;
      mDisp    = '0;
      mShMask  = '0;
      mDMask   = '0;
      mPending = 0;
      expSeg   = 7'b1111111;
      expSel   = 4'b1111;
      expFd    = 1'b0;
    end else begin
      if (running && enable) begin
        curDigit = (tick / SCAN_DIV) % DIGITS;
        expSeg   = modelDigit(curDigit);
        expSel   = ~(4'b0001 << curDigit);
        expFd    = ((tick % FRAME) == FRAME - 1);
        tick++;
        if (expFd) begin
          frames++;
          if (mPending) begin
            mDisp    = mShadow;
            mDMask   = mShMask;
            mPending = 0;
          end
        end
      end else begin
        expSeg = 7'b1111111;
        expSel = 4'b1111;
        expFd  = 1'b0;
        if (!running && mPending) begin
          mDisp    = mShadow;
          mDMask   = mShMask;
          mPending = 0;
        end
      end
      running = enable;
      if (!enable) tick = 0;
      if (load) begin
        mShadow  = value;
        mShMask  = blinkMask;
        mPending = 1;
      end
    end
  end

  task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (modelValid) begin
      compareValue("modelSegments", {25'd0, segments}, {25'd0, expSeg});
      compareValue("modelDigitSel", {28'd0, digitSel}, {28'd0, expSel});
      compareValue("modelFrameDone", {31'd0, frameDone}, {31'd0, expFd});
    end
  end

  task automatic checkOutput(input string name, input logic [6:0] seg, input logic [3:0] sel,
                             input logic fd);
    compareValue({name, "_seg"}, {25'd0, segments}, {25'd0, seg});
    compareValue({name, "_sel"}, {28'd0, digitSel}, {28'd0, sel});
    compareValue({name, "_fd"}, {31'd0, frameDone}, {31'd0, fd});
    compareValue({name, "_modelSeg"}, {25'd0, expSeg}, {25'd0, seg});
  endtask

  task automatic applyStimulus(input logic nr, input logic en, input logic ld,
                               input logic [15:0] v, input logic [3:0] m, input logic bl);
    nReset       = nr;
    enable       = en;
    load         = ld;
    value        = v;
    blinkMask    = m;
    blankLeading = bl;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset, load while dark (lands immediately), enable; returns on the first lit cycle.
  task automatic startFresh(input logic [15:0] v, input logic [3:0] m, input logic bl);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, bl);
    stepCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b1, v, m, bl);
    stepCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0, v, m, bl);
    stepCycles(2);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0);
    stepCycles(3);
    checkOutput("reset", 7'b1111111, 4'b1111, 1'b0);

    // Load while enabling: first frame shows the old zeros, next frame shows 1A2F.
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h1A2F, 4'h0, 1'b0);
    stepCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h1A2F, 4'h0, 1'b0);
    checkOutput("enableDark", 7'b1111111, 4'b1111, 1'b0);
    stepCycles(1);
    checkOutput("t1FirstDigit", 7'b1000000, 4'b1110, 1'b0);
    stepCycles(15);
    checkOutput("t1FrameDone1", 7'b1000000, 4'b0111, 1'b1);
    stepCycles(1);
    checkOutput("t1Digit0", 7'b0001110, 4'b1110, 1'b0);
    stepCycles(4);
    checkOutput("t1Digit1", 7'b0100100, 4'b1101, 1'b0);
    stepCycles(4);
    checkOutput("t1Digit2", 7'b0001000, 4'b1011, 1'b0);
    stepCycles(4);
    checkOutput("t1Digit3", 7'b1111001, 4'b0111, 1'b0);
    stepCycles(3);
    checkOutput("t1FrameDone2", 7'b1111001, 4'b0111, 1'b1);
    stepCycles(1);
    checkOutput("t1Wrap", 7'b0001110, 4'b1110, 1'b0);

    // Leading-zero blanking.
    startFresh(16'h0007, 4'h0, 1'b1);
    checkOutput("t2Digit0", 7'b1111000, 4'b1110, 1'b0);
    stepCycles(4);
    checkOutput("t2Digit1", 7'b1111111, 4'b1101, 1'b0);
    stepCycles(4);
    checkOutput("t2Digit2", 7'b1111111, 4'b1011, 1'b0);
    stepCycles(4);
    checkOutput("t2Digit3", 7'b1111111, 4'b0111, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0000, 4'h0, 1'b1);
    stepCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 4'h0, 1'b1);
    stepCycles(3);
    checkOutput("t2Zero0", 7'b1000000, 4'b1110, 1'b0);
    stepCycles(4);
    checkOutput("t2Zero1", 7'b1111111, 4'b1101, 1'b0);
    stepCycles(8);
    checkOutput("t2Zero3", 7'b1111111, 4'b0111, 1'b0);

    // Last write wins; a load on the boundary with one already pending waits a frame.
    startFresh(16'h3333, 4'h0, 1'b0);
    checkOutput("t3Old0", 7'b0110000, 4'b1110, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h1111, 4'h0, 1'b0);
    stepCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h2222, 4'h0, 1'b0);
    stepCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h2222, 4'h0, 1'b0);
    stepCycles(2);
    checkOutput("t3Hold1", 7'b0110000, 4'b1101, 1'b0);
    stepCycles(12);
    checkOutput("t3New0", 7'b0100100, 4'b1110, 1'b0);
    stepCycles(4);
    checkOutput("t3New1", 7'b0100100, 4'b1101, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h5555, 4'h0, 1'b0);
    stepCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h5555, 4'h0, 1'b0);
    stepCycles(9);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h4444, 4'h0, 1'b0);
    stepCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h4444, 4'h0, 1'b0);
    checkOutput("t3Boundary", 7'b0100100, 4'b0111, 1'b1);
    stepCycles(1);
    checkOutput("t3Pending0", 7'b0010010, 4'b1110, 1'b0);
    stepCycles(16);
    checkOutput("t3Late0", 7'b0011001, 4'b1110, 1'b0);

    // Blink digit 0 with a two-frame half period.
    startFresh(16'h8888, 4'b0001, 1'b0);
    checkOutput("t4Frame0", 7'b0000000, 4'b1110, 1'b0);
    stepCycles(16);
    checkOutput("t4Frame1", 7'b0000000, 4'b1110, 1'b0);
    stepCycles(16);
    checkOutput("t4Frame2Blank", 7'b1111111, 4'b1110, 1'b0);
    stepCycles(4);
    checkOutput("t4Frame2Digit1", 7'b0000000, 4'b1101, 1'b0);
    stepCycles(12);
    checkOutput("t4Frame3Blank", 7'b1111111, 4'b1110, 1'b0);
    stepCycles(16);
    checkOutput("t4Frame4", 7'b0000000, 4'b1110, 1'b0);

    // Disable mid digit 2, then re-enable from digit 0.
    startFresh(16'h1234, 4'h0, 1'b0);
    checkOutput("t5Digit0", 7'b0011001, 4'b1110, 1'b0);
    stepCycles(9);
    checkOutput("t5Digit2", 7'b0100100, 4'b1011, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h1234, 4'h0, 1'b0);
    stepCycles(1);
    checkOutput("t5Dark", 7'b1111111, 4'b1111, 1'b0);
    stepCycles(2);
    checkOutput("t5Idle", 7'b1111111, 4'b1111, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h1234, 4'h0, 1'b0);
    stepCycles(1);
    checkOutput("t5ReDark", 7'b1111111, 4'b1111, 1'b0);
    stepCycles(1);
    checkOutput("t5ReDigit0", 7'b0011001, 4'b1110, 1'b0);
    stepCycles(3);
    checkOutput("t5ReDigit0End", 7'b0011001, 4'b1110, 1'b0);
    stepCycles(1);
    checkOutput("t5ReDigit1", 7'b0110000, 4'b1101, 1'b0);

    // Reset mid-scan with a coincident load.
    startFresh(16'h9999, 4'h0, 1'b0);
    stepCycles(5);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hABCD, 4'hF, 1'b0);
    stepCycles(1);
    checkOutput("t6Reset", 7'b1111111, 4'b1111, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'hABCD, 4'hF, 1'b0);
    stepCycles(1);
    checkOutput("t6Idle", 7'b1111111, 4'b1111, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'hABCD, 4'hF, 1'b0);
    stepCycles(2);
    checkOutput("t6Digit0", 7'b1000000, 4'b1110, 1'b0);
    stepCycles(4);
    checkOutput("t6Digit1", 7'b1000000, 4'b1101, 1'b0);
    stepCycles(4);
    checkOutput("t6Digit2", 7'b1000000, 4'b1011, 1'b0);
    stepCycles(4);
    checkOutput("t6Digit3", 7'b1000000, 4'b0111, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
